alu_issue_arbiter: RTL and testbench



---
 rtl/alu_issue_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_issue_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Shares NUM_ALU ALU instances among issuing wavefronts: round-robin grant of a free,
// ready ALU, per-ALU issue-to-completion tracking and round-robin completion reporting.
module alu_issue_arbiter #(
  parameter int NUM_ALU = 4,
  parameter int WFID_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_issue_valid,
  input  logic [WFID_W-1:0]   in_issue_wfid,
  output logic                out_issue_ack,
  output logic [2:0]          out_issue_alu,
  input  logic [NUM_ALU-1:0]  in_alu_ready,
  input  logic [NUM_ALU-1:0]  in_instr_done,
  output logic [NUM_ALU-1:0]  out_alu_select,
  output logic [NUM_ALU-1:0]  out_alu_select_flopped,
  output logic [NUM_ALU-1:0]  out_busy,
  output logic                out_all_busy,
  output logic                out_done_valid,
  output logic [WFID_W-1:0]   out_done_wfid,
  output logic [2:0]          out_done_alu,
  output logic                out_protocol_err
);

  localparam int IDX_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    PEND = 2'd2
  } alu_state_e;

  alu_state_e        state  [NUM_ALU];
  logic [WFID_W-1:0] wfid_q [NUM_ALU];
  logic [2:0]        issue_ptr;
  logic [2:0]        done_ptr;

  logic [NUM_ALU-1:0] eligible;
  logic [NUM_ALU-1:0] pending;
  logic [NUM_ALU-1:0] in_busy;
  logic [NUM_ALU-1:0] report_sel;
  logic [2:0]         grant_idx;
  logic [2:0]         done_idx;

  // First requester at or after ptr, wrapping modulo NUM_ALU.
  function automatic logic [2:0] rr_pick(input logic [NUM_ALU-1:0] req, input logic [2:0] ptr);
    int j;
    rr_pick = '0;
    for (int k = NUM_ALU - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_ALU) j = j - NUM_ALU;
      if (req[j[IDX_W-1:0]]) rr_pick = 3'(j);
    end
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (int'(idx) == NUM_ALU - 1) ? 3'd0 : idx + 3'd1;
  endfunction

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    eligible   = '0;
    pending    = '0;
    in_busy    = '0;
    out_busy   = '0;
    report_sel = '0;
    for (int i = 0; i < NUM_ALU; i++) begin
      eligible[i] = (state[i] == IDLE) && in_alu_ready[i];
      pending[i]  = (state[i] == PEND);
      in_busy[i]  = (state[i] == BUSY);
      out_busy[i] = (state[i] != IDLE);
    end
    grant_idx      = rr_pick(eligible, issue_ptr);
    done_idx       = rr_pick(pending, done_ptr);
    out_issue_ack  = in_issue_valid && (|eligible);
    out_issue_alu  = out_issue_ack ? grant_idx : 3'd0;
    out_alu_select = '0;
    if (out_issue_ack) out_alu_select[grant_idx[IDX_W-1:0]] = 1'b1;
    if (|pending) report_sel[done_idx[IDX_W-1:0]] = 1'b1;
    out_all_busy = &out_busy;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the wfid store is reset too, so a stale id can never surface after rst.
      for (int i = 0; i < NUM_ALU; i++) begin
        state[i]  <= IDLE;
        wfid_q[i] <= '0;
      end
      issue_ptr              <= '0;
      done_ptr               <= '0;
      out_alu_select_flopped <= '0;
      out_done_valid         <= 1'b0;
      out_done_wfid          <= '0;
      out_done_alu           <= '0;
      out_protocol_err       <= 1'b0;
    end else begin
      out_alu_select_flopped <= out_alu_select;
      if (out_issue_ack) issue_ptr <= next_idx(grant_idx);

      out_done_valid <= |pending;
      if (|pending) begin
        out_done_wfid <= wfid_q[done_idx[IDX_W-1:0]];
        out_done_alu  <= done_idx;
        done_ptr      <= next_idx(done_idx);
      end

      // A done pulse on an ALU that is not BUSY is flagged and otherwise ignored.
      if (|(in_instr_done & ~in_busy)) out_protocol_err <= 1'b1;

      for (int i = 0; i < NUM_ALU; i++) begin
        case (state[i])
          IDLE: if (out_alu_select[i]) begin
            state[i]  <= BUSY;
            wfid_q[i] <= in_issue_wfid;
          end
          BUSY:    if (in_instr_done[i]) state[i] <= PEND;
          PEND:    if (report_sel[i]) state[i] <= IDLE;
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed self-checking bench for alu_issue_arbiter (NUM_ALU=4, WFID_W=6).
module tb_alu_issue_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_issue_valid;
  logic [5:0] in_issue_wfid;
  logic       out_issue_ack;
  logic [2:0] out_issue_alu;
  logic [3:0] in_alu_ready;
  logic [3:0] in_instr_done;
  logic [3:0] out_alu_select;
  logic [3:0] out_alu_select_flopped;
  logic [3:0] out_busy;
  logic       out_all_busy;
  logic       out_done_valid;
  logic [5:0] out_done_wfid;
  logic [2:0] out_done_alu;
  logic       out_protocol_err;

  int checks = 0;
  int errors = 0;

  alu_issue_arbiter #(.NUM_ALU(4), .WFID_W(6)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_issue_valid         (in_issue_valid),
    .in_issue_wfid          (in_issue_wfid),
    .out_issue_ack          (out_issue_ack),
    .out_issue_alu          (out_issue_alu),
    .in_alu_ready           (in_alu_ready),
    .in_instr_done          (in_instr_done),
    .out_alu_select         (out_alu_select),
    .out_alu_select_flopped (out_alu_select_flopped),
    .out_busy               (out_busy),
    .out_all_busy           (out_all_busy),
    .out_done_valid         (out_done_valid),
    .out_done_wfid          (out_done_wfid),
    .out_done_alu           (out_done_alu),
    .out_protocol_err       (out_protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    tick();
    rst = 1'b0;
  endtask

  // Offer one instruction, check the same-cycle grant, then clock it in.
  task automatic offer(input string tag, input logic [5:0] wfid, input logic [2:0] exp_alu);
    in_issue_valid = 1'b1;
    in_issue_wfid  = wfid;
    #1;
    check({tag, "_ack"}, 32'(out_issue_ack), 32'd1);
    check({tag, "_alu"}, 32'(out_issue_alu), 32'(exp_alu));
    check({tag, "_sel"}, 32'(out_alu_select), 32'(4'b0001 << exp_alu));
    tick();
    in_issue_valid = 1'b0;
    check({tag, "_flop"}, 32'(out_alu_select_flopped), 32'(4'b0001 << exp_alu));
  endtask

  task automatic expect_report(input string tag, input logic [5:0] wfid, input logic [2:0] alu);
    check({tag, "_valid"}, 32'(out_done_valid), 32'd1);
    check({tag, "_wfid"}, 32'(out_done_wfid), 32'(wfid));
    check({tag, "_alu"}, 32'(out_done_alu), 32'(alu));
  endtask

  initial begin
    rst            = 1'b1;
    in_issue_valid = 1'b0;
    in_issue_wfid  = '0;
    in_alu_ready   = 4'b1111;
    in_instr_done  = '0;
    #12;
    check("rst_ack", 32'(out_issue_ack), 32'd0);
    check("rst_busy", 32'(out_busy), 32'd0);
    check("rst_all_busy", 32'(out_all_busy), 32'd0);
    check("rst_done_valid", 32'(out_done_valid), 32'd0);
    check("rst_flop", 32'(out_alu_select_flopped), 32'd0);
    check("rst_err", 32'(out_protocol_err), 32'd0);
    rst = 1'b0;

    // 1: first grant goes to ALU0
    offer("t1", 6'd5, 3'd0);
    check("t1_busy", 32'(out_busy), 32'h1);

    // 2: four back-to-back offers fill the pool, the fifth stalls
    do_reset();
    offer("t2a", 6'd1, 3'd0);
    offer("t2b", 6'd2, 3'd1);
    offer("t2c", 6'd3, 3'd2);
    offer("t2d", 6'd4, 3'd3);
    check("t2_busy", 32'(out_busy), 32'hF);
    check("t2_all_busy", 32'(out_all_busy), 32'd1);
    in_issue_valid = 1'b1;
    in_issue_wfid  = 6'd9;
    #1;
    check("t2_stall_ack", 32'(out_issue_ack), 32'd0);
    check("t2_stall_sel", 32'(out_alu_select), 32'd0);
    tick();
    in_issue_valid = 1'b0;
    check("t2_stall_flop", 32'(out_alu_select_flopped), 32'd0);

    // 3: simultaneous done on ALU1 and ALU3, reported on consecutive cycles
    in_instr_done = 4'b1010;
    tick();
    in_instr_done = 4'b0000;
    check("t3_no_early_valid", 32'(out_done_valid), 32'd0);
    check("t3_busy_pend", 32'(out_busy), 32'hF);
    tick();
    expect_report("t3_r1", 6'd2, 3'd1);
    check("t3_busy_r1", 32'(out_busy), 32'hD);
    tick();
    expect_report("t3_r2", 6'd4, 3'd3);
    check("t3_busy_r2", 32'(out_busy), 32'h5);
    tick();
    check("t3_idle_valid", 32'(out_done_valid), 32'd0);
    check("t3_hold_wfid", 32'(out_done_wfid), 32'd4);
    check("t3_hold_alu", 32'(out_done_alu), 32'd3);
    check("t3_err", 32'(out_protocol_err), 32'd0);

    // 4/5 setup: issue pointer to 2, both ALUs complete, done pointer to 2
    do_reset();
    offer("t4a", 6'd10, 3'd0);
    offer("t4b", 6'd11, 3'd1);
    in_instr_done = 4'b0011;
    tick();
    in_instr_done = 4'b0000;
    tick();
    expect_report("t4_r0", 6'd10, 3'd0);
    tick();
    expect_report("t4_r1", 6'd11, 3'd1);

    // 5: stray done on idle ALU0
    in_instr_done = 4'b0001;
    tick();
    in_instr_done = 4'b0000;
    check("t5_err", 32'(out_protocol_err), 32'd1);
    check("t5_busy", 32'(out_busy), 32'h0);
    tick();
    check("t5_no_report", 32'(out_done_valid), 32'd0);
    check("t5_err_sticky", 32'(out_protocol_err), 32'd1);

    // 4: pointer 2, ALU2 (and ALU1) not ready -> ALU3, then wrap to ALU0
    in_alu_ready = 4'b1001;
    offer("t4_wrap", 6'd7, 3'd3);
    in_alu_ready = 4'b1111;
    offer("t4_ptr0", 6'd8, 3'd0);
    check("t4_busy", 32'(out_busy), 32'h9);

    // 6: reset while ALU0 and ALU3 are PEND
    in_instr_done = 4'b1001;
    tick();
    in_instr_done = 4'b0000;
    check("t6_busy_pend", 32'(out_busy), 32'h9);
    check("t6_valid_pre", 32'(out_done_valid), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_done_valid), 32'd0);
    check("t6_rst_busy", 32'(out_busy), 32'd0);
    check("t6_rst_err", 32'(out_protocol_err), 32'd0);
    check("t6_rst_wfid", 32'(out_done_wfid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_no_stale_1", 32'(out_done_valid), 32'd0);
    tick();
    check("t6_no_stale_2", 32'(out_done_valid), 32'd0);
    // both pointers back at 0
    offer("t6_g0", 6'd20, 3'd0);
    offer("t6_g1", 6'd21, 3'd1);
    in_instr_done = 4'b0011;
    tick();
    in_instr_done = 4'b0000;
    tick();
    expect_report("t6_r0", 6'd20, 3'd0);
    tick();
    expect_report("t6_r1", 6'd21, 3'd1);
    tick();
    check("t6_final_valid", 32'(out_done_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
